// File: rtl/pc_redirect_unit.sv
// Fetch-PC register with branch/jump redirect, a two-cycle pipeline flush,
// misaligned-target trapping and a saturating redirect counter.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    // Counter value loaded on reset; left at zero except to preload a test.
    parameter logic [15:0] CNT_PRELOAD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        jump,
    input  logic [31:0] PC_plus_X,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        flush,
    output logic        trap,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        trap_q, trap_d;
    logic [15:0] cnt_q, cnt_d;
    logic        redirect_s;
    logic [31:0] pc_seq_s;

    assign redirect_s = br_taken | jump;
    assign pc_seq_s   = pc_q + 32'd4;

    // Next-state, next-PC and status computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        trap_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect_s) begin
                    state_d = FLUSH1;
                    flush_d = 1'b1;
                    if (PC_plus_X[1:0] == 2'b00) begin
                        pc_d = PC_plus_X;
                    end else begin
                        pc_d   = TRAP_VEC;
                        trap_d = 1'b1;
                    end
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (!stall) begin
                    pc_d = pc_seq_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            // Redirect inputs here belong to squashed instructions.
            FLUSH1: begin
                state_d = FLUSH2;
                flush_d = 1'b1;
                if (!stall) begin
                    pc_d = pc_seq_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            FLUSH2: begin
                state_d = RUN;
                flush_d = 1'b0;
                if (!stall) begin
                    pc_d = pc_seq_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = RUN;
                pc_d    = pc_q;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
            cnt_q   <= CNT_PRELOAD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC           = pc_q;
    assign PC_plus_4    = pc_seq_s;
    assign flush        = flush_q;
    assign trap         = trap_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench: stimulus pushes hand-computed post-edge expectations into a
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jump;
    logic [31:0] PC_plus_X;
    logic [31:0] PC, PC_plus_4;
    logic        flush, trap;
    logic [15:0] redirect_cnt;

    logic        s_br, s_jump;
    logic [31:0] s_pc, s_pc4;
    logic        s_flush, s_trap;
    logic [15:0] s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int          id;
        logic [31:0] pc;
        logic        flush;
        logic        trap;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vec_id = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
        .jump(jump), .PC_plus_X(PC_plus_X), .PC(PC), .PC_plus_4(PC_plus_4),
        .flush(flush), .trap(trap), .redirect_cnt(redirect_cnt)
    );

    // Second instance with the counter preloaded near saturation.
    pc_redirect_unit #(.CNT_PRELOAD(16'hFFFE)) sat_dut (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .br_taken(s_br),
        .jump(s_jump), .PC_plus_X(32'h0000_0040), .PC(s_pc), .PC_plus_4(s_pc4),
        .flush(s_flush), .trap(s_trap), .redirect_cnt(s_cnt)
    );

    function automatic void cmp(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h expected %h", name, id, act, exp);
        end
    endfunction

    // Monitor: compare each queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc", e.id, PC, e.pc);
                cmp("pc_plus_4", e.id, PC_plus_4, e.pc + 32'd4);
                cmp("flush", e.id, {31'd0, flush}, {31'd0, e.flush});
                cmp("trap", e.id, {31'd0, trap}, {31'd0, e.trap});
                cmp("redirect_cnt", e.id, {16'd0, redirect_cnt}, {16'd0, e.cnt});
            end
        end
    end

    task automatic expect_now(input logic [31:0] pc, input logic f, input logic t,
                              input logic [15:0] c);
        exp_t e;
        e.id = vec_id; e.pc = pc; e.flush = f; e.trap = t; e.cnt = c;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic step(input logic s, input logic b, input logic j,
                        input logic [31:0] tgt, input logic [31:0] pc,
                        input logic f, input logic t, input logic [15:0] c);
        stall = s; br_taken = b; jump = j; PC_plus_X = tgt;
        @(posedge clk);
        #1;
        expect_now(pc, f, t, c);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
        PC_plus_X = 32'h0; s_br = 1'b0; s_jump = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now(32'h0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Sequential fetch after reset
        step(0, 0, 0, 32'h0, 32'h4,  0, 0, 16'd0);
        step(0, 0, 0, 32'h0, 32'h8,  0, 0, 16'd0);
        step(0, 0, 0, 32'h0, 32'hC,  0, 0, 16'd0);
        step(0, 0, 0, 32'h0, 32'h10, 0, 0, 16'd0);
        // Aligned branch; the br_taken pulse in FLUSH1 must be ignored
        step(0, 1, 0, 32'h40, 32'h40, 1, 0, 16'd1);
        step(0, 1, 0, 32'h80, 32'h44, 1, 0, 16'd1);
        step(0, 0, 0, 32'h0,  32'h48, 0, 0, 16'd1);
        step(0, 0, 0, 32'h0,  32'h4C, 0, 0, 16'd1);
        // Misaligned jump while stalled
        step(1, 0, 1, 32'h42, 32'h100, 1, 1, 16'd2);
        step(1, 0, 0, 32'h0,  32'h100, 1, 0, 16'd2);
        step(1, 0, 0, 32'h0,  32'h100, 0, 0, 16'd2);
        step(1, 0, 0, 32'h0,  32'h100, 0, 0, 16'd2);
        step(0, 0, 0, 32'h0,  32'h104, 0, 0, 16'd2);
        // Simultaneous br_taken and jump count once
        step(0, 1, 1, 32'h200, 32'h200, 1, 0, 16'd3);
        step(0, 0, 0, 32'h0,   32'h204, 1, 0, 16'd3);
        step(0, 0, 0, 32'h0,   32'h208, 0, 0, 16'd3);
        // Misaligned with low bits 01
        step(0, 1, 0, 32'h301, 32'h100, 1, 1, 16'd4);
        step(0, 0, 0, 32'h0,   32'h104, 1, 0, 16'd4);
        step(0, 0, 0, 32'h0,   32'h108, 0, 0, 16'd4);
        // Wrap at the top of the address space, then stall
        step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 16'd5);
        step(1, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 16'd5);
        step(1, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 16'd5);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 16'd5);
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 16'd5);
        step(0, 0, 0, 32'h0, 32'h4, 0, 0, 16'd5);
        // Reset asserted in FLUSH1 acts without a clock edge
        step(0, 1, 0, 32'h80, 32'h80, 1, 0, 16'd6);
        @(negedge clk);
        #1;
        br_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_pc", -1, PC, 32'h0);
        cmp("async_rst_flush", -1, {31'd0, flush}, 32'd0);
        cmp("async_rst_cnt", -1, {16'd0, redirect_cnt}, 32'd0);
        @(posedge clk);
        #1;
        expect_now(32'h0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        step(0, 0, 0, 32'h0,  32'h4,  0, 0, 16'd0);
        step(0, 1, 0, 32'h10, 32'h10, 1, 0, 16'd1);
        step(0, 0, 0, 32'h0,  32'h14, 1, 0, 16'd1);
        step(0, 0, 0, 32'h0,  32'h18, 0, 0, 16'd1);

        // Saturation on the preloaded instance with both inputs high
        @(negedge clk);
        cmp("sat_preload", -2, {16'd0, s_cnt}, {16'd0, 16'hFFFE});
        s_br = 1'b1; s_jump = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            cmp("sat_cnt", k, {16'd0, s_cnt}, {16'd0, 16'hFFFF});
        end
        s_br = 1'b0; s_jump = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
